paddle_position_ctrl: RTL and testbench
=======================================

// Module: paddle_position_ctrl
// PURPOSE
//  Consumes keypad controller intents up1/down1 (P1) and up2/down2 (P2).
//  Integrates them into two registered paddle top-edge Y positions for the Pong renderer and collision logic.
//  Runs in the 100 Hz keypad clock domain. Provides rate-limited movement, field clamping and re-centre on point scored.
// PARAMETERS
//  POS_W      8    width of position outputs
//  FIELD_H    240  playfield height in pixels (rows 0..FIELD_H-1)
//  PADDLE_H   40   paddle height; max top-edge Y = FIELD_H-PADDLE_H
//  STEP       4    pixels moved per step
//  MOVE_DIV   2    edges between steps while a key is held (>=1)
//  ACCEL_HOLD 25   hold edges before fast step (PADDLE_ACCEL_EN only)
//  ACCEL_STEP 8    fast step size (PADDLE_ACCEL_EN only)
// PORTS
//  clk        in   1      100 Hz system tick clock
//  rst        in   1      reset, synchronous, active-low
//  game_run   in   1      1 = paddles may move; 0 = freeze
//  center     in   1      1-cycle pulse: re-centre both paddles
//  up1        in   1      P1 up request
//  down1      in   1      P1 down request
//  up2        in   1      P2 up request
//  down2      in   1      P2 down request
//  paddle1_y  out  POS_W  P1 top-edge Y, registered
//  paddle2_y  out  POS_W  P2 top-edge Y, registered
//  moving1    out  1      P1 FSM not IDLE
//  moving2    out  1      P2 FSM not IDLE
// BEHAVIOUR
//  - Reset (rst=0 at posedge): paddleN_y = Y_CTR = (FIELD_H-PADDLE_H)/2 = 100; movingN=0; FSM IDLE; counters 0.
//  - Priority per edge: rst > center > !game_run > key movement.
//  - center=1: y=Y_CTR, FSM IDLE, counters cleared. Applies even when game_run=0.
//  - game_run=0: y holds; FSM forced IDLE; counters cleared.
//  - Per-player FSM, states IDLE, UP, DOWN:
//    - req = up&!down -> UP; down&!up -> DOWN; else (none or both) -> IDLE.
//    - Edge k counts from 0 at state entry. A step is applied at each k with k%MOVE_DIV==0.
//    - So the first step lands on the same edge at which the key is first sampled. Zero extra latency.
//    - Direction reversal (UP<->DOWN) is a new entry: k=0, immediate step.
//    - Release: -> IDLE at that edge, no step.
//  - Arithmetic: UP: y = (y<s) ? 0 : y-s; DOWN: y = (y+s > Y_MAX) ? Y_MAX : y+s.
//    - Computed at POS_W+1 bits; no wrap ever.
//    - At a limit the FSM stays UP/DOWN and moving stays 1; y holds.
//  - P1 and P2 are fully independent; simultaneous keys on both players are legal.
//  - Reset mid-move: returns to reset values at that edge.
// CONFIGURATION
//  PADDLE_ACCEL_EN defined:
//    - A per-player hold counter, saturating at ACCEL_HOLD, sets s = (k>=ACCEL_HOLD) ? ACCEL_STEP : STEP.
//    - The counter is cleared on entry/IDLE/center/!game_run.
//  Not defined: s = STEP always; hold counter not instantiated.
// STRUCTURE
//  - Shared package pong_pkg holds:
//    - FIELD_H, PADDLE_H, Y_CTR, Y_MAX constants;
//    - FSM state encoding (IDLE=2'd0, UP=2'd1, DOWN=2'd2).
//    The renderer and ball logic use the same package.
//  - One sub-module, paddle_axis: single-player FSM, divider, clamp, accel.
//    Instantiated twice; the top level only does priority gating and wiring.
// TESTING (defaults)
//  1. rst=0 two edges then rst=1, no keys -> paddle1_y=paddle2_y=100, moving=0.
//  2. up1 held 10 edges from 100 -> steps at k=0,2,4,6,8 -> paddle1_y=80, moving1=1; release -> moving1=0, y=80.
//  3. down2 held from 196 -> 200 and stays 200 for 20 edges; up1 held from 2 -> 0, no wrap to 254.
//  4. up1 and down2 together 4 edges from 100/100 -> 92/108; then up1&down1 both high -> P1 IDLE, y frozen.
//  5. up1 held, center pulse at edge 5 -> both y=100 next edge, FSM IDLE; game_run=0 with keys held -> y frozen.
//  6. PADDLE_ACCEL_EN: down2 held 30 edges from 100 -> 13x4 + 2x8 -> 168; without macro -> 160.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong constants and paddle FSM state encoding; also used by renderer and ball logic.
package pong_pkg;

  localparam int FIELD_H  = 240;
  localparam int PADDLE_H = 40;
  localparam int Y_MAX    = FIELD_H - PADDLE_H;
  localparam int Y_CTR    = Y_MAX / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } axis_state_t;

endpackage

// File: rtl/paddle_axis.sv
// Single-player paddle axis: IDLE/UP/DOWN FSM, step divider, clamp and optional
// hold acceleration (enabled by defining PADDLE_ACCEL_EN).
module paddle_axis
  import pong_pkg::*;
#(
  parameter int POS_W      = 8,
  parameter int Y_CTR      = 100,
  parameter int Y_MAX      = 200,
  parameter int STEP       = 4,
  parameter int MOVE_DIV   = 2,
  parameter int ACCEL_HOLD = 25,
  parameter int ACCEL_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             freeze,
  input  logic             up,
  input  logic             down,
  output logic [POS_W-1:0] y,
  output logic             moving
);

  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
  localparam logic [POS_W:0]   STEP_X   = (POS_W+1)'(STEP);
  localparam logic [POS_W:0]   Y_MAX_X  = (POS_W+1)'(Y_MAX);
  localparam logic [POS_W-1:0] Y_CTR_Y  = POS_W'(Y_CTR);

  axis_state_t state, state_nxt, req;
  logic [DIV_W-1:0] div_cnt, div_nxt, div_k;
  logic [POS_W-1:0] y_nxt;
  logic [POS_W:0]   y_ext, s;
  logic             entry;

`ifdef PADDLE_ACCEL_EN
  localparam int HOLD_W = $clog2(ACCEL_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT     = HOLD_W'(ACCEL_HOLD);
  localparam logic [POS_W:0]    ACCEL_STEP_X = (POS_W+1)'(ACCEL_STEP);
  logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_k;

  always_ff @(posedge clk) begin
    if (!rst) hold_cnt <= '0;
    else      hold_cnt <= hold_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      y       <= Y_CTR_Y;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      y       <= y_nxt;
    end
  end

  always_comb begin
    req = ST_IDLE;
    if (up && !down)      req = ST_UP;
    else if (down && !up) req = ST_DOWN;
  end

  // A change of requested direction restarts the edge count, so the first
  // step of any new press (or reversal) lands on the sampling edge itself.
  assign entry = (req != state);
  assign div_k = entry ? '0 : div_cnt;
  assign y_ext = {1'b0, y};

`ifdef PADDLE_ACCEL_EN
  assign hold_k = entry ? '0 : hold_cnt;
  assign s      = (hold_k >= HOLD_SAT) ? ACCEL_STEP_X : STEP_X;
`else
  assign s      = STEP_X;
`endif

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    y_nxt     = y;
`ifdef PADDLE_ACCEL_EN
    hold_nxt  = hold_cnt;
`endif
    if (clear || freeze || req == ST_IDLE) begin
      state_nxt = ST_IDLE;
      div_nxt   = '0;
`ifdef PADDLE_ACCEL_EN
      hold_nxt  = '0;
`endif
      if (clear) y_nxt = Y_CTR_Y;
    end else begin
      state_nxt = req;
      div_nxt   = (div_k == DIV_LAST) ? '0 : DIV_W'(div_k + 1'b1);
`ifdef PADDLE_ACCEL_EN
      hold_nxt  = (hold_k == HOLD_SAT) ? hold_k : HOLD_W'(hold_k + 1'b1);
`endif
      // Clamp computed one bit wider than the position so it can never wrap.
      if (div_k == '0) begin
        if (req == ST_UP)
          y_nxt = POS_W'((y_ext < s) ? '0 : (y_ext - s));
        else
          y_nxt = POS_W'(((y_ext + s) > Y_MAX_X) ? Y_MAX_X : (y_ext + s));
      end
    end
  end

  assign moving = (state != ST_IDLE);

endmodule

// File: rtl/paddle_position_ctrl.sv
// Two-player paddle position controller: priority gating and two paddle_axis
// instances. Optional hold acceleration via macro PADDLE_ACCEL_EN.
module paddle_position_ctrl
  import pong_pkg::*;
#(
  parameter int POS_W      = 8,
  parameter int FIELD_H    = pong_pkg::FIELD_H,
  parameter int PADDLE_H   = pong_pkg::PADDLE_H,
  parameter int STEP       = 4,
  parameter int MOVE_DIV   = 2,
  parameter int ACCEL_HOLD = 25,
  parameter int ACCEL_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_run,
  input  logic             center,
  input  logic             up1,
  input  logic             down1,
  input  logic             up2,
  input  logic             down2,
  output logic [POS_W-1:0] paddle1_y,
  output logic [POS_W-1:0] paddle2_y,
  output logic             moving1,
  output logic             moving2
);

  localparam int Y_MAX_P = FIELD_H - PADDLE_H;
  localparam int Y_CTR_P = Y_MAX_P / 2;

  logic freeze, keys_en;

  assign freeze  = !game_run && !center;
  assign keys_en = game_run && !center;

  paddle_axis #(
    .POS_W(POS_W), .Y_CTR(Y_CTR_P), .Y_MAX(Y_MAX_P), .STEP(STEP),
    .MOVE_DIV(MOVE_DIV), .ACCEL_HOLD(ACCEL_HOLD), .ACCEL_STEP(ACCEL_STEP)
  ) u_axis1 (
    .clk(clk), .rst(rst), .clear(center), .freeze(freeze),
    .up(up1 && keys_en), .down(down1 && keys_en),
    .y(paddle1_y), .moving(moving1)
  );

  paddle_axis #(
    .POS_W(POS_W), .Y_CTR(Y_CTR_P), .Y_MAX(Y_MAX_P), .STEP(STEP),
    .MOVE_DIV(MOVE_DIV), .ACCEL_HOLD(ACCEL_HOLD), .ACCEL_STEP(ACCEL_STEP)
  ) u_axis2 (
    .clk(clk), .rst(rst), .clear(center), .freeze(freeze),
    .up(up2 && keys_en), .down(down2 && keys_en),
    .y(paddle2_y), .moving(moving2)
  );

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Scoreboard bench for paddle_position_ctrl: directed scenarios plus random key traffic
// against a behavioural model.
module tb_paddle_position_ctrl;

  localparam int STEP_T       = 4;
  localparam int MOVE_DIV_T   = 2;
  localparam int ACCEL_HOLD_T = 25;
  localparam int ACCEL_STEP_T = 8;
  localparam int YMAX_T       = 200;
  localparam int YCTR_T       = 100;

  logic clk = 1'b0;
  logic rst = 1'b0, game_run = 1'b0, center = 1'b0;
  logic up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
  logic [7:0] paddle1_y, paddle2_y;
  logic moving1, moving2;

  always #5 clk = ~clk;

  paddle_position_ctrl #(
    .POS_W(8), .FIELD_H(240), .PADDLE_H(40), .STEP(STEP_T),
    .MOVE_DIV(MOVE_DIV_T), .ACCEL_HOLD(ACCEL_HOLD_T), .ACCEL_STEP(ACCEL_STEP_T)
  ) dut (
    .clk(clk), .rst(rst), .game_run(game_run), .center(center),
    .up1(up1), .down1(down1), .up2(up2), .down2(down2),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .moving1(moving1), .moving2(moving2)
  );

  typedef struct { int y1; int y2; bit m1; bit m2; } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int pushed = 0;
  int popped = 0;

  // Model: position, direction held (0 none, -1 up, +1 down), edges since press.
  int my[2];
  int mdir[2];
  int mk[2];

  task automatic model_player(input int p, input bit r, input bit run, input bit c,
                              input bit u, input bit d);
    int want, s;
    want = (u && !d) ? -1 : (d && !u) ? 1 : 0;
    if (!r || c) begin
      my[p] = YCTR_T; mdir[p] = 0; mk[p] = 0;
    end else if (!run || want == 0) begin
      mdir[p] = 0; mk[p] = 0;
    end else begin
      if (want != mdir[p]) begin
        mdir[p] = want; mk[p] = 0;
      end
      s = STEP_T;
`ifdef PADDLE_ACCEL_EN
      if (mk[p] >= ACCEL_HOLD_T) s = ACCEL_STEP_T;
`endif
      if (mk[p] % MOVE_DIV_T == 0) begin
        my[p] = my[p] + want * s;
        if (my[p] < 0) my[p] = 0;
        if (my[p] > YMAX_T) my[p] = YMAX_T;
      end
      mk[p] = mk[p] + 1;
    end
  endtask

  task automatic tick(input bit r, input bit run, input bit c,
                      input bit u1, input bit d1, input bit u2, input bit d2);
    exp_t e;
    @(negedge clk);
    rst = r; game_run = run; center = c;
    up1 = u1; down1 = d1; up2 = u2; down2 = d2;
    model_player(0, r, run, c, u1, d1);
    model_player(1, r, run, c, u2, d2);
    e.y1 = my[0]; e.y2 = my[1]; e.m1 = (mdir[0] != 0); e.m2 = (mdir[1] != 0);
    sb.push_back(e);
    pushed++;
  endtask

  task automatic ticks(input int n, input bit run, input bit c,
                       input bit u1, input bit d1, input bit u2, input bit d2);
    for (int i = 0; i < n; i++) tick(1'b1, run, c, u1, d1, u2, d2);
  endtask

  task automatic check_now(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Directed checks sample just after the edge that follows the last tick.
  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are valid after every edge that had stimulus queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        tests++;
        if (paddle1_y != 8'(e.y1) || paddle2_y != 8'(e.y2) ||
            moving1 != e.m1 || moving2 != e.m2) begin
          fails++;
          $display("FAIL sb_cycle%0d: got y1=%0d y2=%0d m1=%0b m2=%0b, expected y1=%0d y2=%0d m1=%0b m2=%0b",
                   popped, paddle1_y, paddle2_y, moving1, moving2, e.y1, e.y2, e.m1, e.m2);
        end
      end
    end
  end

  initial begin
    bit r, run, c, u1, d1, u2, d2;
    for (int p = 0; p < 2; p++) begin
      my[p] = YCTR_T; mdir[p] = 0; mk[p] = 0;
    end

    // Reset and idle
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check_now("reset_y1", int'(paddle1_y), 100);
    check_now("reset_y2", int'(paddle2_y), 100);
    check_now("reset_mv", int'({moving1, moving2}), 0);

    // up1 held 10 edges: five steps of 4
    ticks(10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check_now("up10_y1", int'(paddle1_y), 80);
    check_now("up10_mv1", int'(moving1), 1);
    ticks(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check_now("release_mv1", int'(moving1), 0);
    check_now("release_y1", int'(paddle1_y), 80);

    // Limits: P2 to bottom and held there, P1 to top without wrap
    ticks(70, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    check_now("bottom_y2", int'(paddle2_y), 200);
    check_now("bottom_mv2", int'(moving2), 1);
    ticks(60, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check_now("top_y1", int'(paddle1_y), 0);
    check_now("top_mv1", int'(moving1), 1);

    // Re-centre, then both players together, then conflicting keys on P1
    ticks(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check_now("both_y1", int'(paddle1_y), 92);
    check_now("both_y2", int'(paddle2_y), 108);
    ticks(3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check_now("conflict_y1", int'(paddle1_y), 92);
    check_now("conflict_mv1", int'(moving1), 0);

    // Centre pulse during a hold, then game_run low with keys held
    ticks(5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check_now("center_y1", int'(paddle1_y), 100);
    check_now("center_y2", int'(paddle2_y), 100);
    check_now("center_mv1", int'(moving1), 0);
    ticks(5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check_now("freeze_y1", int'(paddle1_y), 100);
    check_now("freeze_y2", int'(paddle2_y), 100);
    check_now("freeze_mv", int'({moving1, moving2}), 0);

    // 30-edge hold: acceleration kicks in after 25 edges when enabled
    ticks(30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
`ifdef PADDLE_ACCEL_EN
    check_now("hold30_y2", int'(paddle2_y), 168);
`else
    check_now("hold30_y2", int'(paddle2_y), 160);
`endif

    // Random traffic: keys persist for a while, occasional centre/freeze/reset
    run = 1'b1; u1 = 1'b0; d1 = 1'b0; u2 = 1'b0; d2 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) {u1, d1} = 2'($urandom);
      if ($urandom_range(0, 7) == 0) {u2, d2} = 2'($urandom);
      if ($urandom_range(0, 39) == 0) run = ~run;
      c = ($urandom_range(0, 79) == 0);
      r = ($urandom_range(0, 299) != 0);
      tick(r, run, c, u1, d1, u2, d2);
    end

    settle();
    settle();
    tests++;
    if (sb.size() != 0 || popped != pushed) begin
      fails++;
      $display("FAIL sb_drain: got %0d popped with %0d left, expected %0d popped with 0 left",
               popped, sb.size(), pushed);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
